lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Parametrised LCD raster timing generator and pixel pipeline; next generation of the team's fixed-timing LCD driver.
- Sits between the PLL-derived pixel clock and the pixel source (character/key display logic). Issues pixel coordinates and takes back pixel_data after a configurable source latency.
- Drives a sync-aligned RGB panel bus in HV mode or DE-only mode, with programmable sync polarity and frame-delayed backlight enable.

Parameters:
H_SYNC, 41, hsync width (clocks)
H_BACK, 2, horizontal back porch
H_DISP, 480, active pixels per line
H_FRONT, 2, horizontal front porch
V_SYNC, 10, vsync width (lines)
V_BACK, 2, vertical back porch
V_DISP, 272, active lines
V_FRONT, 2, vertical front porch
PIX_LAT, 1, pixel source latency in clocks from pixel_xpos/ypos to pixel_data (0..7)
HS_POL, 0, active level of lcd_hs
VS_POL, 0, active level of lcd_vs
DE_MODE, 0, 1 = hs/vs held at inactive level and only lcd_de is used
RGB_W, 16, pixel width
POS_W, 10, coordinate width
BL_FRAMES, 2, complete frames after reset before lcd_bl asserts (0 = assert at first frame start)

Ports:
lcd_clk  in  1  pixel clock; every register is clocked on its rising edge
sys_rst  in  1  synchronous, active-high reset
blank  in  1  forces lcd_rgb to 0, sampled with pixel_data; timing is not affected
pixel_data  in  RGB_W  pixel value for the coordinates issued PIX_LAT clocks earlier
pixel_xpos  out  POS_W  column of the requested pixel
pixel_ypos  out  POS_W  row of the requested pixel
pixel_req  out  1  high when pixel_xpos/ypos address an active pixel
lcd_hs  out  1  horizontal sync
lcd_vs  out  1  vertical sync
lcd_de  out  1  data enable
lcd_rgb  out  RGB_W  pixel bus
lcd_bl  out  1  backlight enable
lcd_rst  out  1  panel reset, active low
lcd_pclk  out  1  equals lcd_clk, forwarded directly
frame_start  out  1  one-clock pulse on the first clock of each frame at the panel pins
frame_cnt  out  8  number of completed frames, wraps 255 -> 0

Behaviour:
- Constants: H_TOTAL = sum of H_*. V_TOTAL = sum of V_*. HSTART = H_SYNC+H_BACK. VSTART = V_SYNC+V_BACK.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Both counters are 0 out of reset.
- Stage-0 timing decode, from the counters:
  - hs0 = h_cnt < H_SYNC.
  - vs0 = v_cnt < V_SYNC.
  - act0 = h_cnt in [HSTART, HSTART+H_DISP) and v_cnt in [VSTART, VSTART+V_DISP).
- Stage 1 (registered):
  - pixel_req = act0.
  - When act0: pixel_xpos = h_cnt-HSTART and pixel_ypos = v_cnt-VSTART. Otherwise both are 0.
- The pixel source returns data PIX_LAT clocks after stage 1.
- lcd_rgb is a register:
  - Captures pixel_data when the delayed act is high and blank is low.
  - Captures 0 otherwise.
- hs0, vs0 and act0 pass through a shift delay of exactly 2+PIX_LAT clocks, so lcd_hs/lcd_vs/lcd_de align with lcd_rgb.
- Sync outputs:
  - lcd_hs = HS_POL when delayed hs is high, else ~HS_POL. lcd_vs is formed the same way with VS_POL.
  - If DE_MODE=1, lcd_hs = ~HS_POL and lcd_vs = ~VS_POL permanently.
- frame_start: high for one clock when the delayed counter position equals (0,0).
- frame_cnt:
  - Increments on every frame_start except the first frame_start after reset.
  - It therefore counts completed frames.
- lcd_bl:
  - 0 from reset.
  - Asserts on the clock after frame_cnt reaches BL_FRAMES.
  - Once asserted it stays high until reset; a frame_cnt wrap does not drop it.
  - With BL_FRAMES=0 it asserts on the clock after the first frame_start.
- lcd_rst: 0 while sys_rst is high; registered 1 on the first clock after sys_rst goes low.
- Reset values:
  - Counters, the delay line, pixel_xpos/ypos, pixel_req, lcd_de, lcd_rgb, frame_start, frame_cnt and lcd_bl are all 0.
  - lcd_hs = ~HS_POL and lcd_vs = ~VS_POL.
- Reset asserted mid-frame: everything returns to the reset values on the next edge, and the next frame starts from (0,0). No partial-line completion.
- blank toggling: affects only lcd_rgb, with the same alignment as pixel_data.
- Elaboration constraints:
  - H_DISP and V_DISP must each be at most 2^POS_W.
  - PIX_LAT must be at most 7.
  - All porch and sync values must be at least 1. A violation fails elaboration.

Test Plan:
All scenarios use the small-timing configuration: H 2/3/8/2, V 1/2/4/1, PIX_LAT=1, HS_POL=VS_POL=0 (H_TOTAL=15, V_TOTAL=8, frame 120 clocks).
- Reset, then run one frame; pixel source returns xpos as pixel_data:
  - First pixel_req at clock 15*3+5+1 = 51 after reset release, with xpos 0 and ypos 0.
  - lcd_de first high at clock 53, with lcd_rgb=0.
  - Exactly 32 clocks of lcd_de per frame.
  - lcd_rgb per line is 0..7.
- Sync checks:
  - lcd_hs is low for 2 clocks of every 15 and lcd_vs is low for 15 of every 120 clocks, each offset +3 clocks from the counters.
  - Rerun with HS_POL=1: lcd_hs is inverted.
  - Rerun with DE_MODE=1: lcd_hs and lcd_vs stay constantly 1.
- PIX_LAT=3 with a 3-deep source pipeline: lcd_de is first high at clock 55 and lcd_rgb stays column-aligned with no skew.
- blank high for lines 1-2 of active video: lcd_rgb is 0 on those lines while lcd_de is unchanged.
- BL_FRAMES=2:
  - frame_start pulses every 120 clocks; frame_cnt reads 1, 2, 3, ...
  - lcd_bl rises one clock after frame_cnt becomes 2.
  - Force 256 frames: frame_cnt wraps to 0 and lcd_bl stays 1.
- sys_rst pulsed at clock 70, mid active line:
  - Next edge: lcd_de=0, lcd_rgb=0, frame_cnt=0, lcd_bl=0, lcd_rst=0.
  - After release: lcd_rst=1 one clock later and the first pixel_req again at clock 51.

Source files
------------

// File: rtl/lcd_timing_gen_if.sv
// Pixel source bus between the LCD timing generator and the pixel source.
// The generator (master) issues coordinates; the source (slave) returns pixel_data and blank.
interface lcd_timing_gen_if #(
    parameter int unsigned RGB_W = 16,
    parameter int unsigned POS_W = 10
);
    logic [POS_W-1:0] pixel_xpos;
    logic [POS_W-1:0] pixel_ypos;
    logic             pixel_req;
    logic [RGB_W-1:0] pixel_data;
    logic             blank;

    modport master (
        output pixel_xpos, pixel_ypos, pixel_req,
        input  pixel_data, blank
    );

    modport slave (
        input  pixel_xpos, pixel_ypos, pixel_req,
        output pixel_data, blank
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD raster timing generator with a pixel-source pipeline.
// It delays the sync/DE timing so the panel pins line up with the registered lcd_rgb.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC    = 41,
    parameter int unsigned H_BACK    = 2,
    parameter int unsigned H_DISP    = 480,
    parameter int unsigned H_FRONT   = 2,
    parameter int unsigned V_SYNC    = 10,
    parameter int unsigned V_BACK    = 2,
    parameter int unsigned V_DISP    = 272,
    parameter int unsigned V_FRONT   = 2,
    parameter int unsigned PIX_LAT   = 1,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter logic        DE_MODE   = 1'b0,
    parameter int unsigned RGB_W     = 16,
    parameter int unsigned POS_W     = 10,
    parameter int unsigned BL_FRAMES = 2
) (
    input  logic             lcd_clk,
    input  logic             sys_rst,
    lcd_timing_gen_if.master pix,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic             lcd_de,
    output logic [RGB_W-1:0] lcd_rgb,
    output logic             lcd_bl,
    output logic             lcd_rst,
    output logic             lcd_pclk,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HSTART  = H_SYNC + H_BACK;
    localparam int unsigned VSTART  = V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DLY     = 2 + PIX_LAT;

    if (H_DISP > 2**POS_W || V_DISP > 2**POS_W) begin : g_pos_w_err
        $fatal(1, "lcd_timing_gen: H_DISP/V_DISP exceed 2**POS_W");
    end
    if (PIX_LAT > 7) begin : g_pix_lat_err
        $fatal(1, "lcd_timing_gen: PIX_LAT must be at most 7");
    end
    if (H_SYNC < 1 || H_BACK < 1 || H_FRONT < 1 || H_DISP < 1 ||
        V_SYNC < 1 || V_BACK < 1 || V_FRONT < 1 || V_DISP < 1) begin : g_porch_err
        $fatal(1, "lcd_timing_gen: sync, porch and display values must be at least 1");
    end
    if (BL_FRAMES > 255) begin : g_bl_err
        $fatal(1, "lcd_timing_gen: BL_FRAMES must fit in frame_cnt");
    end

    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           hs0, vs0, act0, fs0;
    logic [DLY-1:0] hs_dly, vs_dly, act_dly, fs_dly;
    logic           seen_first;
    logic           bl_hit;

    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        hs0  = h_cnt < HW'(H_SYNC);
        vs0  = v_cnt < VW'(V_SYNC);
        act0 = (h_cnt >= HW'(HSTART)) && (h_cnt < HW'(HSTART + H_DISP)) &&
               (v_cnt >= VW'(VSTART)) && (v_cnt < VW'(VSTART + V_DISP));
        fs0  = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            pix.pixel_req  <= 1'b0;
            pix.pixel_xpos <= '0;
            pix.pixel_ypos <= '0;
        end else begin
            pix.pixel_req  <= act0;
            pix.pixel_xpos <= act0 ? POS_W'(h_cnt - HW'(HSTART)) : '0;
            pix.pixel_ypos <= act0 ? POS_W'(v_cnt - VW'(VSTART)) : '0;
        end
    end

    // lcd_rgb captures at the same edge the DE tap goes high, so the capture gate
    // uses the tap one stage earlier than the one driving lcd_de.
    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            hs_dly  <= '0;
            vs_dly  <= '0;
            act_dly <= '0;
            fs_dly  <= '0;
            lcd_rgb <= '0;
        end else begin
            hs_dly  <= {hs_dly[DLY-2:0], hs0};
            vs_dly  <= {vs_dly[DLY-2:0], vs0};
            act_dly <= {act_dly[DLY-2:0], act0};
            fs_dly  <= {fs_dly[DLY-2:0], fs0};
            lcd_rgb <= (act_dly[DLY-2] && !pix.blank) ? pix.pixel_data : '0;
        end
    end

    assign lcd_de      = act_dly[DLY-1];
    assign frame_start = fs_dly[DLY-1];
    assign lcd_hs      = DE_MODE ? ~HS_POL : (hs_dly[DLY-1] ? HS_POL : ~HS_POL);
    assign lcd_vs      = DE_MODE ? ~VS_POL : (vs_dly[DLY-1] ? VS_POL : ~VS_POL);
    assign lcd_pclk    = lcd_clk;

    // The first frame_start opens frame 0, so it does not count as a completed frame.
    assign bl_hit = (BL_FRAMES == 0) ? frame_start : (frame_cnt == 8'(BL_FRAMES));

    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            seen_first <= 1'b0;
            frame_cnt  <= '0;
            lcd_bl     <= 1'b0;
            lcd_rst    <= 1'b0;
        end else begin
            lcd_rst <= 1'b1;
            if (frame_start) begin
                seen_first <= 1'b1;
                if (seen_first) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
            if (bl_hit) begin
                lcd_bl <= 1'b1;
            end
        end
    end

endmodule
